// File: rtl/wm_writer_pkg.sv
// -----------------------------------------------------------------------------
// wm_writer_pkg
// Shared definitions for the weight-memory write path.
//   - WM_OFFSET_BITS(rows, cols): number of low address bits that select a word
//     inside one weight page. The reader (ls_array) and writer (wm_writer) must
//     agree on this split, so both derive it from the same expression.
//   - wm_offset_bits(): function form of the same split, usable in localparams.
//   - wm_sat_len(): clamps a requested transfer length to the memory size.
// -----------------------------------------------------------------------------
`ifndef WM_OFFSET_BITS
`define WM_OFFSET_BITS(rows, cols) $clog2((rows) * (cols))
`endif

package wm_writer_pkg;

   // Page/offset split of a weight-memory address.
   function automatic int wm_offset_bits(input int rows, input int cols);
      return `WM_OFFSET_BITS(rows, cols);
   endfunction

   // Transfer lengths beyond the memory size would only overwrite words
   // already written in the same transfer, so they are clamped.
   function automatic int wm_sat_len(input int req_len, input int mem_words);
      return (req_len > mem_words) ? mem_words : req_len;
   endfunction

endpackage

// File: rtl/wm_addr_gen.sv
// -----------------------------------------------------------------------------
// wm_addr_gen
// Page/offset address counter for the weight memory. Kept independent of the
// writer FSM so the read side can reuse it.
//   clk        in  : clock, rising edge
//   reset      in  : synchronous, active-high
//   load       in  : load page from load_addr, clear offset
//   load_addr  in  : start address; only the page field is used
//   inc        in  : advance to the next word address
//   addr       out : current {page, offset}
// The offset walks 0..ROWS*COLUMNS-1, then the page advances. The last memory
// word (MEM_WORDS-1) wraps back to address 0.
// -----------------------------------------------------------------------------
module wm_addr_gen
   import wm_writer_pkg::*;
#(
   parameter int ROWS      = 4,
   parameter int COLUMNS   = 4,
   parameter int ADDR_W    = 32,
   parameter int MEM_WORDS = 2048
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic              inc,
   output logic [ADDR_W-1:0] addr
);

   localparam int OFF_W  = wm_offset_bits(ROWS, COLUMNS);
   localparam int PAGE_W = ADDR_W - OFF_W;
   localparam logic [OFF_W-1:0]  OFF_LAST  = OFF_W'(ROWS * COLUMNS - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MEM_WORDS - 1);

   logic [PAGE_W-1:0] page_q,   page_d;
   logic [OFF_W-1:0]  offset_q, offset_d;

   // Offset bits of the start address are deliberately discarded: every
   // transfer begins at the top of a page.
   logic unused_low_bits;
   assign unused_low_bits = ^load_addr[OFF_W-1:0];

   assign addr = {page_q, offset_q};

   always_comb begin
      page_d   = page_q;
      offset_d = offset_q;
      if (load) begin
         page_d   = load_addr[ADDR_W-1:OFF_W];
         offset_d = '0;
      end else if (inc) begin
         if (addr == ADDR_LAST) begin
            page_d   = '0;
            offset_d = '0;
         end else if (offset_q == OFF_LAST) begin
            page_d   = page_q + PAGE_W'(1);
            offset_d = '0;
         end else begin
            offset_d = offset_q + OFF_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         page_q   <= '0;
         offset_q <= '0;
      end else begin
         page_q   <= page_d;
         offset_q <= offset_d;
      end
   end

endmodule

// File: rtl/wm_writer.sv
// -----------------------------------------------------------------------------
// wm_writer
// Pops 64-bit weight words from a first-word-fall-through FIFO and writes them
// to consecutive weight-memory addresses starting at the top of a given page.
//   clk, reset        : clock / synchronous active-high reset
//   enable            : global hold; when low nothing advances and no pops
//   start             : one-cycle request, sampled only in IDLE
//   start_value_wm    : start address (page field used, offset forced to 0)
//   wr_length         : words to write, clamped to size_wmemory
//   fifo_empty/data   : FWFT FIFO status and head word
//   fifo_read         : combinational pop
//   wm_we/address/data: registered memory write port
//   busy, done        : status (done is a one-cycle pulse in DONE)
//   words_written     : words written in the current or last transfer
// FSM: IDLE -> LOAD (one pop/write per available word) -> DRAIN (last write
// visible) -> DONE -> IDLE. A zero-length request goes straight to DONE.
// -----------------------------------------------------------------------------
module wm_writer
   import wm_writer_pkg::*;
#(
   parameter int ROWS            = 4,
   parameter int COLUMNS         = 4,
   parameter int data_in_mem     = 64,
   parameter int address_leng_wm = 32,
   parameter int size_wmemory    = 2048
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             enable,
   input  logic                             start,
   input  logic [address_leng_wm-1:0]       start_value_wm,
   input  logic [$clog2(size_wmemory):0]    wr_length,
   input  logic                             fifo_empty,
   input  logic [data_in_mem-1:0]           fifo_data,
   output logic                             fifo_read,
   output logic                             wm_we,
   output logic [address_leng_wm-1:0]       wm_address,
   output logic [data_in_mem-1:0]           wm_data,
   output logic                             busy,
   output logic                             done,
   output logic [$clog2(size_wmemory):0]    words_written
);

   localparam int LEN_W = $clog2(size_wmemory) + 1;
   localparam logic [LEN_W-1:0] MEM_LEN = LEN_W'(size_wmemory);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]                 state_q,     state_d;
   logic [LEN_W-1:0]           remaining_q, remaining_d;
   logic [LEN_W-1:0]           written_q,   written_d;
   logic                       we_q,        we_d;
   logic [address_leng_wm-1:0] addr_q,      addr_d;
   logic [data_in_mem-1:0]     data_q,      data_d;

   logic                       ag_load;
   logic                       ag_inc;
   logic [address_leng_wm-1:0] ag_addr;
   logic [LEN_W-1:0]           len_sat;
   logic                       pop;

   wm_addr_gen #(
      .ROWS      (ROWS),
      .COLUMNS   (COLUMNS),
      .ADDR_W    (address_leng_wm),
      .MEM_WORDS (size_wmemory)
   ) u_addr_gen (
      .clk       (clk),
      .reset     (reset),
      .load      (ag_load),
      .load_addr (start_value_wm),
      .inc       (ag_inc),
      .addr      (ag_addr)
   );

   assign len_sat = (wr_length > MEM_LEN) ? MEM_LEN : wr_length;

   // The remaining != 0 term keeps a late FIFO word from being popped in the
   // same cycle the FSM leaves LOAD.
   assign pop = (state_q == S_LOAD) & enable & ~fifo_empty & (remaining_q != '0);

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      written_d   = written_q;
      we_d        = 1'b0;
      addr_d      = addr_q;
      data_d      = data_q;
      ag_load     = 1'b0;
      ag_inc      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start && enable) begin
               ag_load     = 1'b1;
               remaining_d = len_sat;
               written_d   = '0;
               state_d     = (len_sat != '0) ? S_LOAD : S_DONE;
            end
         end
         S_LOAD: begin
            if (pop) begin
               we_d        = 1'b1;
               addr_d      = ag_addr;
               data_d      = fifo_data;
               ag_inc      = 1'b1;
               remaining_d = remaining_q - LEN_W'(1);
               written_d   = written_q + LEN_W'(1);
               if (remaining_q == LEN_W'(1)) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (enable) begin
               state_d = S_DONE;
            end
         end
         default: begin
            if (enable) begin
               state_d = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         remaining_q <= '0;
         written_q   <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         written_q   <= written_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
      end
   end

   assign fifo_read     = pop;
   assign wm_we         = we_q;
   assign wm_address    = addr_q;
   assign wm_data       = data_q;
   assign busy          = (state_q != S_IDLE);
   assign done          = (state_q == S_DONE);
   assign words_written = written_q;

endmodule

// File: tb/tb_wm_writer.sv
module tb_wm_writer;

   logic        clk;
   logic        reset;
   logic        enable;
   logic        start;
   logic [31:0] start_value_wm;
   logic [11:0] wr_length;
   logic        fifo_empty;
   logic [63:0] fifo_data;
   logic        fifo_read;
   logic        wm_we;
   logic [31:0] wm_address;
   logic [63:0] wm_data;
   logic        busy;
   logic        done;
   logic [11:0] words_written;

   wm_writer dut (
      .clk            (clk),
      .reset          (reset),
      .enable         (enable),
      .start          (start),
      .start_value_wm (start_value_wm),
      .wr_length      (wr_length),
      .fifo_empty     (fifo_empty),
      .fifo_data      (fifo_data),
      .fifo_read      (fifo_read),
      .wm_we          (wm_we),
      .wm_address     (wm_address),
      .wm_data        (wm_data),
      .busy           (busy),
      .done           (done),
      .words_written  (words_written)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [31:0] start_value;
      logic [11:0] wr_length;
      int          npush;
      int          bubble_after;
      int          bubble_len;
      int          en_after;
      int          en_len;
      int          start_after;
      int          exp_writes;
      int          exp_gaps;
   } vec_t;

   vec_t        vecs[5];
   logic [63:0] fq[$];
   logic [63:0] expq[$];
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          pops  = 0;
   int          first_pop;
   int          last_pop;
   logic        stall = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: present FIFO head, note whether the DUT pops, advance past the
   // edge and retire the popped word. Outputs are then sampled for cycle cyc.
   task automatic cycle();
      logic pop_flag;
      fifo_empty = stall || (fq.size() == 0);
      fifo_data  = (fq.size() != 0) ? fq[0] : 64'd0;
      #2;
      pop_flag = fifo_read && !fifo_empty;
      @(posedge clk);
      #1;
      if (pop_flag) begin
         void'(fq.pop_front());
         pops++;
         if (first_pop < 0) first_pop = cyc;
         last_pop = cyc;
      end
      cyc++;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      logic [31:0] base;
      logic [63:0] w;
      int t, nwr, first_we, last_we, done_cyc, idle_cyc, bub, enc;
      bit sp_done;
      fq.delete();
      expq.delete();
      for (int i = 0; i < v.npush; i++) begin
         w = {32'hC0DE0000 + 32'(idx), 32'(i)};
         fq.push_back(w);
         expq.push_back(w);
      end
      pops = 0; first_pop = -1; last_pop = -1;
      nwr = 0; first_we = -1; last_we = -1; done_cyc = -1; idle_cyc = -1;
      bub = 0; enc = 0; sp_done = 0;
      base = v.start_value & 32'hFFFF_FFF0;

      enable = 1'b1; stall = 1'b0;
      start = 1'b1; start_value_wm = v.start_value; wr_length = v.wr_length;
      t = cyc;
      cycle();
      start = 1'b0;

      for (int k = 0; k < 4000; k++) begin
         stall = 1'b0; enable = 1'b1; start = 1'b0;
         if (v.bubble_len > 0 && pops == v.bubble_after && bub < v.bubble_len) begin
            stall = 1'b1; bub++;
         end
         if (v.en_len > 0 && pops == v.en_after && enc < v.en_len) begin
            enable = 1'b0; enc++;
         end
         if (v.start_after >= 0 && pops == v.start_after && !sp_done) begin
            start = 1'b1; start_value_wm = 32'h400; sp_done = 1;
         end
         cycle();
         if (wm_we) begin
            chk($sformatf("v%0d addr[%0d]", idx, nwr), 64'(wm_address),
                64'((base + 32'(nwr)) % 32'd2048));
            if (expq.size() != 0) chk($sformatf("v%0d data[%0d]", idx, nwr), wm_data, expq.pop_front());
            else chk($sformatf("v%0d extra write", idx), 64'(nwr), 64'(v.exp_writes));
            nwr++;
            if (first_we < 0) first_we = cyc;
            last_we = cyc;
         end
         if (done && done_cyc < 0) done_cyc = cyc;
         if (!busy) begin
            idle_cyc = cyc;
            break;
         end
      end
      start = 1'b0; stall = 1'b0; enable = 1'b1;

      if (idle_cyc < 0) chk($sformatf("v%0d timeout", idx), 64'd0, 64'd1);
      chk($sformatf("v%0d writes", idx), 64'(nwr), 64'(v.exp_writes));
      chk($sformatf("v%0d pops", idx), 64'(pops), 64'(v.exp_writes));
      chk($sformatf("v%0d first pop", idx), 64'(first_pop), 64'(t + 1));
      chk($sformatf("v%0d done cycle", idx), 64'(done_cyc), 64'(last_pop + 2));
      chk($sformatf("v%0d idle cycle", idx), 64'(idle_cyc), 64'(last_pop + 3));
      chk($sformatf("v%0d words_written", idx), 64'(words_written), 64'(v.exp_writes));
      chk($sformatf("v%0d gaps", idx), 64'(last_we - first_we + 1 - nwr), 64'(v.exp_gaps));
      $display("vec %0d: start=%0h len=%0d writes=%0d pops=%0d done@%0d", idx,
               v.start_value, v.wr_length, nwr, pops, done_cyc);
   endtask

   initial begin
      int nwr, stray;

      vecs[0] = '{32'h020, 12'd16,   16,   -1, 0, -1, 0, -1, 16,   0};
      vecs[1] = '{32'h020, 12'd16,   16,    6, 3, -1, 0, -1, 16,   3};
      vecs[2] = '{32'h7F0, 12'd20,   20,   -1, 0, -1, 0, -1, 20,   0};
      vecs[3] = '{32'h000, 12'd3000, 2100, -1, 0, -1, 0, -1, 2048, 0};
      vecs[4] = '{32'h100, 12'd12,   12,   -1, 0,  5, 2,  3, 12,   2};

      reset = 1'b1; enable = 1'b0; start = 1'b0; start_value_wm = '0; wr_length = '0;
      fifo_empty = 1'b1; fifo_data = '0;
      first_pop = -1; last_pop = -1;
      @(posedge clk); #1;
      cycle();
      cycle();
      reset = 1'b0;
      enable = 1'b1;
      cycle();
      chk("reset wm_we", 64'(wm_we), 64'd0);
      chk("reset wm_address", 64'(wm_address), 64'd0);
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset done", 64'(done), 64'd0);
      chk("reset words_written", 64'(words_written), 64'd0);
      $display("reset: busy=%0d done=%0d we=%0d", busy, done, wm_we);

      for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

      // Zero length: DONE straight after start, FIFO left untouched.
      fq.delete();
      for (int i = 0; i < 4; i++) fq.push_back(64'(i + 100));
      pops = 0; first_pop = -1; last_pop = -1;
      start = 1'b1; start_value_wm = 32'h50; wr_length = 12'd0;
      cycle();
      start = 1'b0;
      chk("zero done t+1", 64'(done), 64'd1);
      chk("zero busy t+1", 64'(busy), 64'd1);
      chk("zero wm_we t+1", 64'(wm_we), 64'd0);
      chk("zero fifo_read t+1", 64'(fifo_read), 64'd0);
      cycle();
      chk("zero done t+2", 64'(done), 64'd0);
      chk("zero busy t+2", 64'(busy), 64'd0);
      cycle();
      chk("zero pops", 64'(pops), 64'd0);
      $display("zero-length: pops=%0d", pops);

      // Reset after the 7th write.
      fq.delete();
      for (int i = 0; i < 16; i++) fq.push_back(64'(i + 500));
      pops = 0; first_pop = -1; last_pop = -1;
      start = 1'b1; start_value_wm = 32'h30; wr_length = 12'd16;
      cycle();
      start = 1'b0;
      nwr = 0;
      for (int k = 0; k < 100 && nwr < 7; k++) begin
         cycle();
         if (wm_we) nwr++;
      end
      chk("rst reached 7 writes", 64'(nwr), 64'd7);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      chk("rst wm_we", 64'(wm_we), 64'd0);
      chk("rst wm_address", 64'(wm_address), 64'd0);
      chk("rst wm_data", wm_data, 64'd0);
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst done", 64'(done), 64'd0);
      chk("rst words_written", 64'(words_written), 64'd0);
      chk("rst fifo_read", 64'(fifo_read), 64'd0);
      stray = 0;
      for (int k = 0; k < 5; k++) begin
         cycle();
         if (wm_we || fifo_read || busy) stray++;
      end
      chk("rst no activity", 64'(stray), 64'd0);
      $display("reset mid-stream: writes before reset=%0d stray=%0d", nwr, stray);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
